// File: rtl/lsu_mmio_pkg.sv
// Shared types, address map constants and lane helpers for the MMIO load/store unit.
package lsu_mmio_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    localparam logic [31:0] DMEM_BASE   = 32'h0000_0000;
    localparam logic [31:0] OUT_BASE    = 32'h1000_0000;
    localparam logic [31:0] IN_BASE     = 32'h1001_0000;
    localparam logic [31:0] PAGE_STRIDE = 32'h0000_1000;
    localparam logic [31:0] EDGE_OFS    = 32'h0000_0004;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Selects the addressed lanes of a full word and extends them to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_B:    return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enable data memory with a synchronous, enable-gated read port.
module lsu_dmem
    import lsu_mmio_pkg::*;
#(
    parameter int WORDS = 2048,
    localparam int AW   = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    // Read data only moves on a read enable, so a stalled response keeps its word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/lsu_mmio_pipe.sv
// Load/store unit: request decode, single-entry response register, output
// registers and synchronised input ports with rising-edge capture.
module lsu_mmio_pipe
    import lsu_mmio_pkg::*;
#(
    parameter int DMEM_WORDS  = 2048,
    parameter int N_OUT       = 5,
    parameter int N_IN        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [31:0]         i_req_addr,
    input  logic [1:0]          i_req_size,
    input  logic                i_req_unsigned,
    input  logic [31:0]         i_req_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [31:0]         o_rsp_rdata,
    output logic                o_rsp_err,
    input  logic [N_IN*32-1:0]  i_ph_in,
    output logic [N_OUT*32-1:0] o_ph_out
);

    localparam int          AW         = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

    logic        r_rsp_valid, r_rsp_err, r_is_load, r_from_dmem, r_uns;
    logic [1:0]  r_off, r_size;
    logic [31:0] r_word;
    logic [31:0] r_ph_out [N_OUT];
    logic [31:0] w_sync [N_IN];
    logic [31:0] w_edge [N_IN];
    logic [31:0] w_dmem_q, w_reg_word, w_wmask, w_wdata_sh;
    logic [3:0]  w_be, w_page;
    logic [1:0]  w_off;
    logic [9:0]  w_word_ofs;
    logic        w_accept, w_store, w_load, w_err, w_size_err, w_misalign;
    logic        w_hit_dmem, w_hit_out, w_in_page, w_hit_in, w_hit_edge;

    assign o_req_ready = !r_rsp_valid | i_rsp_ready;
    assign w_accept    = i_req_valid & o_req_ready;

    assign w_off      = i_req_addr[1:0];
    assign w_page     = i_req_addr[15:12];
    assign w_word_ofs = i_req_addr[11:2];
    assign w_size_err = (i_req_size == 2'b11);
    assign w_misalign = ((i_req_size == SZ_H) && w_off[0]) || ((i_req_size == SZ_W) && (w_off != 2'b00));
    assign w_hit_dmem = (i_req_addr - DMEM_BASE) < DMEM_BYTES;
    assign w_hit_out  = (i_req_addr[31:16] == OUT_BASE[31:16]) && ({1'b0, w_page} < 5'(N_OUT))
                        && (w_word_ofs == 10'd0);
    assign w_in_page  = (i_req_addr[31:16] == IN_BASE[31:16]) && ({1'b0, w_page} < 5'(N_IN));
    assign w_hit_in   = w_in_page && (w_word_ofs == 10'd0);
    assign w_hit_edge = w_in_page && (w_word_ofs == EDGE_OFS[11:2]);
    assign w_err      = w_size_err | w_misalign | !(w_hit_dmem | w_hit_out | w_hit_in | w_hit_edge);

    assign w_be       = byte_en(i_req_size, w_off);
    assign w_wmask    = lane_mask(w_be);
    assign w_wdata_sh = i_req_wdata << {w_off, 3'b000};
    assign w_store    = w_accept & i_req_we & !w_err;
    assign w_load     = w_accept & !i_req_we & !w_err;

    always_comb begin
        w_reg_word = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_hit_out && (w_page == 4'(k))) w_reg_word = r_ph_out[k];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (w_hit_in && (w_page == 4'(k)))   w_reg_word = w_sync[k];
            if (w_hit_edge && (w_page == 4'(k))) w_reg_word = w_edge[k];
        end
    end

    lsu_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
        .i_clk   (i_clk),
        .i_we    (w_store & w_hit_dmem),
        .i_be    (w_be),
        .i_re    (w_load & w_hit_dmem),
        .i_addr  (i_req_addr[AW+1:2]),
        .i_wdata (w_wdata_sh),
        .o_rdata (w_dmem_q)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_OUT; k++) r_ph_out[k] <= '0;
        end else if (w_store && w_hit_out) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_page == 4'(k)) r_ph_out[k] <= (r_ph_out[k] & ~w_wmask) | (w_wdata_sh & w_wmask);
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign o_ph_out[32*k +: 32] = r_ph_out[k];
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        logic [SYNC_STAGES-1:0][31:0] r_sync;
        logic [31:0]                  r_hist, r_edge, w_clr;

        assign w_clr     = (w_store && w_hit_edge && (w_page == 4'(k))) ? w_wmask : '0;
        assign w_sync[k] = r_sync[SYNC_STAGES-1];
        assign w_edge[k] = r_edge;

        // Set wins over a same-cycle write-1-to-clear.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_sync <= '0;
                r_hist <= '0;
                r_edge <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_ph_in[32*k +: 32]};
                r_hist <= r_sync[SYNC_STAGES-1];
                r_edge <= (r_edge & ~w_clr) | (r_sync[SYNC_STAGES-1] & ~r_hist);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_is_load   <= 1'b0;
            r_from_dmem <= 1'b0;
            r_uns       <= 1'b0;
            r_off       <= '0;
            r_size      <= '0;
            r_word      <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_is_load   <= !i_req_we && !w_err;
            r_from_dmem <= w_hit_dmem;
            r_uns       <= i_req_unsigned;
            r_off       <= w_off;
            r_size      <= i_req_size;
            r_word      <= w_reg_word;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_is_load ? load_ext(r_from_dmem ? w_dmem_q : r_word, r_off, r_size, r_uns) : '0;

endmodule

// File: tb/tb_lsu_mmio_pipe.sv
// Directed bench for lsu_mmio_pipe with hand-computed expectations.
module tb_lsu_mmio_pipe;

    localparam int N_OUT = 5;
    localparam int N_IN  = 2;

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_req_valid = 1'b0;
    logic                o_req_ready;
    logic                i_req_we = 1'b0;
    logic [31:0]         i_req_addr = '0;
    logic [1:0]          i_req_size = '0;
    logic                i_req_unsigned = 1'b0;
    logic [31:0]         i_req_wdata = '0;
    logic                o_rsp_valid;
    logic                i_rsp_ready = 1'b1;
    logic [31:0]         o_rsp_rdata;
    logic                o_rsp_err;
    logic [N_IN*32-1:0]  i_ph_in = '0;
    logic [N_OUT*32-1:0] o_ph_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        rsp_vld, rsp_err;
    logic [31:0] rsp_data;

    lsu_mmio_pipe #(.DMEM_WORDS(2048), .N_OUT(N_OUT), .N_IN(N_IN), .SYNC_STAGES(2)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .i_ph_in        (i_ph_in),
        .o_ph_out       (o_ph_out)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = sz;
        i_req_unsigned = uns;
        i_req_wdata    = wd;
    endtask

    // Called at a falling edge with i_rsp_ready high; returns at the next falling edge.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd);
        drive(we, addr, sz, uns, wd);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        rsp_vld  = o_rsp_valid;
        rsp_data = o_rsp_rdata;
        rsp_err  = o_rsp_err;
    endtask

    task automatic ld(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] exp_data, input logic exp_err);
        xfer(1'b0, addr, sz, uns, 32'h0);
        check({tag, "_valid"}, rsp_vld, 1);
        check(tag, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
    endtask

    task automatic st(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                      input logic [31:0] wd, input logic exp_err);
        xfer(1'b1, addr, sz, 1'b0, wd);
        check({tag, "_rdata"}, rsp_data, 32'h0);
        check({tag, "_err"}, rsp_err, exp_err);
    endtask

    initial begin
        #1 i_reset = 1'b1;
        #2;
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_rdata", o_rsp_rdata, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_out0", o_ph_out[31:0], 0);
        check("rst_out4", o_ph_out[159:128], 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_req_ready", o_req_ready, 1);

        // DMEM lanes and extension
        st("sw_100", 32'h100, 2'b10, 32'hDEADBEEF, 0);
        ld("lb_103", 32'h103, 2'b00, 0, 32'hFFFF_FFDE, 0);
        ld("lbu_103", 32'h103, 2'b00, 1, 32'h0000_00DE, 0);
        ld("lh_102", 32'h102, 2'b01, 0, 32'hFFFF_DEAD, 0);
        ld("lhu_100", 32'h100, 2'b01, 1, 32'h0000_BEEF, 0);
        st("sh_102", 32'h102, 2'b01, 32'hFFFF1234, 0);
        ld("lw_100_sh", 32'h100, 2'b10, 0, 32'h1234_BEEF, 0);
        ld("lb_101", 32'h101, 2'b00, 0, 32'hFFFF_FFBE, 0);

        // Output registers
        st("sb_out1", 32'h1000_1001, 2'b00, 32'h0000_00A5, 0);
        check("out1_after_sb", o_ph_out[63:32], 32'h0000_A500);
        check("out0_after_sb", o_ph_out[31:0], 32'h0);
        ld("lw_out1", 32'h1000_1000, 2'b10, 0, 32'h0000_A500, 0);
        st("sw_out4", 32'h1000_4000, 2'b10, 32'hCAFEF00D, 0);
        check("out4_after_sw", o_ph_out[159:128], 32'hCAFE_F00D);

        // Errors leave state untouched
        ld("lh_mis", 32'h101, 2'b01, 0, 32'h0, 1);
        st("sw_unmapped", 32'h2000_0000, 2'b10, 32'h1111_1111, 1);
        st("sw_out_mis", 32'h1000_0002, 2'b10, 32'hFFFF_FFFF, 1);
        st("sb_out5", 32'h1000_5000, 2'b00, 32'hFF, 1);
        ld("lw_rsvd", 32'h100, 2'b11, 0, 32'h0, 1);
        ld("lw_past_dmem", 32'h2000, 2'b10, 0, 32'h0, 1);
        xfer(1'b0, 32'h1FFC, 2'b10, 1'b0, 32'h0);
        check("lw_dmem_top_err", rsp_err, 0);
        ld("lw_100_after_err", 32'h100, 2'b10, 0, 32'h1234_BEEF, 0);
        check("out0_after_err", o_ph_out[31:0], 32'h0);
        check("out1_after_err", o_ph_out[63:32], 32'h0000_A500);
        check("out4_after_err", o_ph_out[159:128], 32'hCAFE_F00D);

        // Back-pressure: response held, request blocked for 3 cycles
        i_rsp_ready = 1'b0;
        drive(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        @(posedge i_clk);
        #1 drive(1'b0, 32'h1000_1001, 2'b00, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("bp_req_ready", o_req_ready, 0);
            check("bp_rsp_valid", o_rsp_valid, 1);
            check("bp_rsp_rdata", o_rsp_rdata, 32'h1234_BEEF);
            check("bp_rsp_err", o_rsp_err, 0);
        end
        i_rsp_ready = 1'b1;
        #1 check("bp_ready_rise", o_req_ready, 1);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        check("bp_next_valid", o_rsp_valid, 1);
        check("bp_next_rdata", o_rsp_rdata, 32'h0000_00A5);

        // Edge capture on port 1 bit 3
        i_ph_in[35] = 1'b1;
        ld("edge_c1", 32'h1001_1004, 2'b10, 0, 32'h0, 0);
        ld("edge_c2", 32'h1001_1004, 2'b10, 0, 32'h0, 0);
        ld("edge_c3", 32'h1001_1004, 2'b10, 0, 32'h0, 0);
        ld("edge_c4", 32'h1001_1004, 2'b10, 0, 32'h8, 0);
        ld("in1_data", 32'h1001_1000, 2'b10, 0, 32'h8, 0);
        st("sw_in_data", 32'h1001_1000, 2'b10, 32'hFFFF_FFFF, 0);
        ld("in1_data_kept", 32'h1001_1000, 2'b10, 0, 32'h8, 0);
        ld("edge_no_side", 32'h1001_1004, 2'b10, 0, 32'h8, 0);
        st("edge_clr", 32'h1001_1004, 2'b10, 32'h8, 0);
        ld("edge_cleared", 32'h1001_1004, 2'b10, 0, 32'h0, 0);
        i_ph_in[35] = 1'b0;
        repeat (4) @(negedge i_clk);
        i_ph_in[35] = 1'b1;
        repeat (2) @(negedge i_clk);
        st("edge_clr_race", 32'h1001_1004, 2'b10, 32'h8, 0);
        ld("edge_set_wins", 32'h1001_1004, 2'b10, 0, 32'h8, 0);

        // Reset while a response is stalled
        i_rsp_ready = 1'b0;
        drive(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        check("pre_rst_valid", o_rsp_valid, 1);
        #2 i_reset = 1'b1;
        #1;
        check("mid_rst_valid", o_rsp_valid, 0);
        check("mid_rst_rdata", o_rsp_rdata, 0);
        check("mid_rst_out1", o_ph_out[63:32], 0);
        check("mid_rst_out4", o_ph_out[159:128], 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("post_rst_ready", o_req_ready, 1);
        i_rsp_ready = 1'b1;
        ld("dmem_survives_rst", 32'h100, 2'b10, 0, 32'h1234_BEEF, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_mmio_pipe.md
# lsu_mmio_pipe

Parametrised load/store unit for the RISC-V core's data port: a valid/ready request channel with a registered, back-pressurable response, covering on-chip data memory, N memory-mapped output registers and N synchronised input ports with rising-edge capture. It handles byte, half and word accesses with lane shifting and sign/zero extension, and flags misaligned or unmapped accesses. It replaces the fixed-map, combinational-read LSU between the execute/memory stage and the board peripherals.

## Interface
- DMEM_WORDS, 2048: data memory depth in 32-bit words, power of two; 8 KiB at default.
- N_OUT, 5: number of 32-bit output registers (LEDR, LEDG, HEX3-0, HEX7-4, LCD).
- N_IN, 2: number of 32-bit input ports (SW, KEY).
- SYNC_STAGES, 2: synchroniser depth on inputs, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid&ready.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_size  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as err.
- i_req_unsigned  in  1  load zero-extends when 1.
- i_req_wdata  in  32  store data, right-aligned (unshifted).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed when valid&ready.
- o_rsp_rdata  out  32  load data, extended; 0 for stores and errors.
- o_rsp_err  out  1  misaligned, unmapped or reserved size.
- i_ph_in  in  N_IN*32  raw asynchronous inputs, port k at [32k+31:32k].
- o_ph_out  out  N_OUT*32  output registers, channel k at [32k+31:32k].

## Operation
- Address map: DMEM 0x0000_0000 to 4*DMEM_WORDS-1; output k word at 0x1000_0000 + k*0x1000; input k data at 0x1001_0000 + k*0x1000, input k edge register at the same base + 0x4. Anything else is unmapped.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
- On an err request: no state change; response has err=1, rdata=0.
- Stores: byte enables derived from size and addr[1:0]; wdata is shifted left by 8*addr[1:0].
  - DMEM and output registers update only the enabled lanes.
  - A store to an input data address is ignored (err=0).
  - A store to an edge register is write-1-to-clear on the enabled lanes.
- Loads: DMEM is a synchronous read, issued on accept. The response selects lanes by the registered addr[1:0] and size, then sign-extends unless unsigned.
  - Output registers return the current value.
  - Input data returns the synchronised value.
  - Edge registers return the captured bits; loads have no side effect.
- Inputs: each bit passes through SYNC_STAGES flops plus one history flop. A rising edge of the synchronised bit sets its edge bit. If a set and a clear hit the same bit in the same cycle, set wins.

## Timing
- Single-entry pipeline.
  - o_req_ready = !o_rsp_valid | i_rsp_ready (combinational).
  - The response appears exactly 1 cycle after accept.
  - Throughput is 1 request/cycle when i_rsp_ready is held high.
- Stores take effect at the accept edge. A load accepted the next cycle sees the new value.
- While o_rsp_valid=1 and i_rsp_ready=0: o_rsp_rdata and o_rsp_err stay stable and no new request is accepted.
- o_ph_out changes on the accept edge of a store.
- An input change becomes visible to loads SYNC_STAGES cycles after it is sampled. The edge bit sets SYNC_STAGES+1 cycles after it is sampled.
- Reset values:
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - o_ph_out=0; synchroniser, history and edge registers=0.
  - o_req_ready=1 once reset deasserts.
  - DMEM contents are not reset.
- Reset asserted mid-transaction drops the pending response. A store accepted on the edge coincident with reset assertion is lost.

## Structure
- Package lsu_mmio_pkg:
  - size enum (SZ_B, SZ_H, SZ_W);
  - DMEM_BASE, OUT_BASE, IN_BASE, PAGE_STRIDE=0x1000, EDGE_OFS=0x4;
  - byte-enable and extension helper functions.
- One sub-module, lsu_dmem: byte-enable synchronous-read RAM, DMEM_WORDS×32, with read enable.
- Top level holds the decode, response register, output registers, synchronisers and edge logic. Synchronisers are a generate loop over N_IN.

## Test plan
- Store word 0xDEADBEEF to 0x100, then lb at 0x103, lbu at 0x103, lh at 0x102 → 0xFFFF_FFDE, 0x0000_00DE, 0xFFFF_DEAD, err=0.
- sb 0xA5 to 0x1000_1001 (channel 1), then lw of the same channel at 0x1000_1000 → o_ph_out[63:32]=0x0000_A500 on the accept edge; load returns 0x0000_A500.
- lh at 0x0000_0101 and sw to 0x2000_0000 → err=1, rdata=0; DMEM and outputs unchanged.
- Issue back-to-back loads with i_rsp_ready low for 3 cycles → o_req_ready low and the response held stable for those 3 cycles; the next request is accepted the cycle i_rsp_ready rises.
- Raise i_ph_in bit 3 of port 1 → edge bit set at SYNC_STAGES+1 cycles; lw at 0x1001_1004 returns 0x8. sw 0x8 to 0x1001_1004 clears it; repeat with a coincident new edge → bit stays set.
- Assert i_reset while a response is stalled → o_rsp_valid=0 and o_ph_out=0 immediately (asynchronous); o_req_ready=1 after release.
